// File: rtl/pipeline_hazard_pkg.sv
// pipeline_hazard_pkg: shadow-stage record, register-address defaults and the register-match helper
package pipeline_hazard_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int REG_AW_MAX = 8;
  localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_AW_MAX-1:0] dest;
    logic                  regWr;
    logic                  load;
  } shadow_t;
  localparam shadow_t SHADOW_NOP = '0;
  // Register 0 never matches; a hit also needs a writer in that stage and a reader in ID
  function automatic logic regHit(shadow_t s, logic [REG_AW_MAX-1:0] rs, logic en);
    return en && rs != REG_ZERO && s.regWr && s.dest == rs;
  endfunction
endpackage

// File: rtl/hazard_shadow_stage.sv
// hazard_shadow_stage: one pipeline shadow register {dest, regWr, load}, cleared by active-low sync reset
module hazard_shadow_stage import pipeline_hazard_pkg::*; (
  input  logic    clk,
  input  logic    reset,
  input  shadow_t d,
  output shadow_t q
);
  always_ff @(posedge clk) q <= !reset ? SHADOW_NOP : d;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use/branch stall and flush control for a 5-stage pipeline.
// Optional stall counter port stallCount is built when HAZARD_STALL_COUNT_EN is defined.
module pipeline_hazard_ctrl import pipeline_hazard_pkg::*; #(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int STALL_CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rS1,
  input  logic [REG_AW-1:0] rS2,
  input  logic [REG_AW-1:0] rW,
  input  logic              useRs1,
  input  logic              useRs2,
  input  logic              regWrId,
  input  logic              loadId,
  input  logic              storeId,
  input  logic              branchId,
  input  logic              branchCond,
  output logic              idFwdA,
  output logic              idFwdB,
  output logic [3:0]        exFwd,
  output logic              memWbMem,
  output logic              ifIdWr,
  output logic              bubble,
  output logic              flush
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [STALL_CW-1:0] stallCount
`endif
);
  if (REG_AW > REG_AW_MAX || REG_AW < 1 || STALL_CW < 1) begin : g_badCfg
    $error("pipeline_hazard_ctrl: unsupported REG_AW/STALL_CW");
  end
  // chain[0] is the ID record entering EX; chain[1..3] are the EX, MEM, WB shadows
  shadow_t chain [4];
  logic exM1, exM2, memM1, memM2, exLd, memLd, stall;
  assign chain[0] = bubble ? SHADOW_NOP : '{dest: REG_AW_MAX'(rW), regWr: regWrId, load: loadId};
  for (genvar i = 0; i < 3; i++) begin : g_stage
    hazard_shadow_stage u_stage (.clk(clk), .reset(reset), .d(chain[i]), .q(chain[i+1]));
  end
  always_comb begin
    exM1     = regHit(chain[1], REG_AW_MAX'(rS1), useRs1);
    exM2     = regHit(chain[1], REG_AW_MAX'(rS2), useRs2);
    memM1    = regHit(chain[2], REG_AW_MAX'(rS1), useRs1);
    memM2    = regHit(chain[2], REG_AW_MAX'(rS2), useRs2);
    exLd     = chain[1].load;
    memLd    = chain[2].load;
    stall    = reset && ((exLd && (exM1 || (exM2 && !storeId)))
                || (branchId && (exM1 || exM2 || (memLd && (memM1 || memM2)))));
    ifIdWr   = !stall;
    bubble   = stall;
    flush    = reset && branchId && branchCond && !stall;
    idFwdA   = reset && branchId && memM1 && !memLd;
    idFwdB   = reset && branchId && memM2 && !memLd;
    exFwd    = reset ? {!exM2 && memM2, !exM1 && memM1, exM2 && !exLd, exM1 && !exLd} : 4'b0;
    memWbMem = reset && storeId && exM2 && exLd && !stall;
  end
`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clk)
    if (!reset) stallCount <= '0;
    else if (stall && stallCount != '1) stallCount <= stallCount + STALL_CW'(1);
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed hazard scenarios plus random instruction streams checked
// against an issued-instruction history model.
module tb_pipeline_hazard_ctrl;
  localparam int SCW = 4;
  typedef struct {int dest; bit wr; bit ld;} rec_t;
  localparam rec_t NOP_R = '{0, 0, 0};

  logic clk = 0, reset = 0;
  logic [4:0] rS1 = 0, rS2 = 0, rW = 0;
  logic useRs1 = 0, useRs2 = 0, regWrId = 0, loadId = 0, storeId = 0, branchId = 0, branchCond = 0;
  logic idFwdA, idFwdB, memWbMem, ifIdWr, bubble, flush;
  logic [3:0] exFwd;
`ifdef HAZARD_STALL_COUNT_EN
  logic [SCW-1:0] stallCount;
`endif

  int checks = 0, errors = 0;
  rec_t hist[$];
  bit expStall, expFlush;
  int cnt = 0;

  pipeline_hazard_ctrl #(.REG_AW(5), .STALL_CW(SCW)) dut (
    .clk(clk), .reset(reset), .rS1(rS1), .rS2(rS2), .rW(rW),
    .useRs1(useRs1), .useRs2(useRs2), .regWrId(regWrId), .loadId(loadId),
    .storeId(storeId), .branchId(branchId), .branchCond(branchCond),
    .idFwdA(idFwdA), .idFwdB(idFwdB), .exFwd(exFwd), .memWbMem(memWbMem),
    .ifIdWr(ifIdWr), .bubble(bubble), .flush(flush)
`ifdef HAZARD_STALL_COUNT_EN
    , .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit hit(rec_t h, int rs, bit en);
    return en && rs != 0 && h.wr && h.dest == rs;
  endfunction

  task automatic check(string tag, logic [9:0] obs, logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setId(int s1, int s2, int w, bit u1, bit u2, bit wr, bit ld, bit st, bit br, bit bc);
    rS1 = 5'(s1); rS2 = 5'(s2); rW = 5'(w);
    useRs1 = u1; useRs2 = u2; regWrId = wr; loadId = ld;
    storeId = st; branchId = br; branchCond = bc;
  endtask

  task automatic nop();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Mid-cycle: derive expected outputs from the two most recently issued instructions
  task automatic cycle(string tag);
    rec_t e, m;
    bit a1, a2, b1, b2;
    logic [9:0] exp;
    #4;
    e = hist[0]; m = hist[1];
    a1 = hit(e, int'(rS1), useRs1); a2 = hit(e, int'(rS2), useRs2);
    b1 = hit(m, int'(rS1), useRs1); b2 = hit(m, int'(rS2), useRs2);
    expStall = reset && ((e.ld && (a1 || (a2 && !storeId)))
               || (branchId && (a1 || a2 || (m.ld && (b1 || b2)))));
    expFlush = reset && branchId && branchCond && !expStall;
    if (!reset) exp = 10'b0000000100;
    else exp = {branchId && b1 && !m.ld, branchId && b2 && !m.ld,
                !a2 && b2, !a1 && b1, a2 && !e.ld, a1 && !e.ld,
                storeId && a2 && e.ld && !expStall, !expStall, expStall, expFlush};
    check(tag, {idFwdA, idFwdB, exFwd, memWbMem, ifIdWr, bubble, flush}, exp);
`ifdef HAZARD_STALL_COUNT_EN
    check({tag, "_cnt"}, 10'(stallCount), 10'(cnt));
`endif
  endtask

  task automatic advance();
    rec_t cur;
    cur = '{int'(rW), regWrId, loadId};
    @(posedge clk);
    if (!reset) begin
      hist = '{NOP_R, NOP_R};
      cnt = 0;
    end else begin
      hist.push_front(expStall ? NOP_R : cur);
      void'(hist.pop_back());
      if (expStall && cnt != (1 << SCW) - 1) cnt++;
    end
    #1;
  endtask

  task automatic idle(int n);
    nop();
    for (int i = 0; i < n; i++) begin cycle("idle"); advance(); end
  endtask

  task automatic loadUse();
    setId(2, 0, 5, 1, 0, 1, 1, 0, 0, 0); cycle("lu_lw"); advance();
    setId(1, 5, 7, 1, 1, 1, 0, 0, 0, 0); cycle("lu_stall"); advance();
    cycle("lu_held"); advance();
  endtask

  initial begin
    hist = '{NOP_R, NOP_R};
    @(posedge clk); #1;
    setId(3, 3, 3, 1, 1, 1, 0, 0, 1, 1);
    cycle("reset_hold");
    check("reset_ifIdWr", 10'(ifIdWr), 10'd1);
    advance();
    reset = 1;
    idle(1);
    check("post_reset_exFwd", 10'(exFwd), 10'd0);
    // ALU result forwarded from EX/MEM
    setId(1, 2, 3, 1, 1, 1, 0, 0, 0, 0); cycle("add_r3"); advance();
    setId(3, 1, 6, 1, 1, 1, 0, 0, 0, 0); cycle("sub_r3");
    check("fwd_exMemExA", 10'(exFwd[0]), 10'd1);
    check("fwd_nostall", 10'(ifIdWr), 10'd1);
    advance(); idle(3);
    // Load-use: one bubble, then MEM/WB forward on operand B
    setId(2, 0, 5, 1, 0, 1, 1, 0, 0, 0); cycle("lw_r5"); advance();
    setId(1, 5, 7, 1, 1, 1, 0, 0, 0, 0); cycle("lu_stall");
    check("lu_ifIdWr", 10'(ifIdWr), 10'd0);
    check("lu_bubble", 10'(bubble), 10'd1);
    advance(); cycle("lu_held");
    check("lu_memWbExB", 10'(exFwd[3]), 10'd1);
    check("lu_resume", 10'(ifIdWr), 10'd1);
    advance(); idle(3);
    // Store data from a load: no stall, forward at MEM
    setId(2, 0, 5, 1, 0, 1, 1, 0, 0, 0); cycle("lw_r5b"); advance();
    setId(2, 5, 0, 1, 1, 0, 0, 1, 0, 0); cycle("sw_r5");
    check("sw_nostall", 10'(ifIdWr), 10'd1);
    check("sw_memWbMem", 10'(memWbMem), 10'd1);
    advance(); idle(3);
    // Branch on a fresh ALU result: one stall, then ID forward and flush
    setId(1, 2, 4, 1, 1, 1, 0, 0, 0, 0); cycle("add_r4"); advance();
    setId(4, 0, 0, 1, 1, 0, 0, 0, 1, 1); cycle("beq_stall");
    check("beq_ifIdWr", 10'(ifIdWr), 10'd0);
    check("beq_noflush", 10'(flush), 10'd0);
    advance(); cycle("beq_go");
    check("beq_idFwdA", 10'(idFwdA), 10'd1);
    check("beq_flush", 10'(flush), 10'd1);
    advance(); idle(3);
    // Branch after load: exactly two stall cycles
    setId(2, 0, 6, 1, 0, 1, 1, 0, 0, 0); cycle("lw_r6"); advance();
    setId(0, 6, 0, 1, 1, 0, 0, 0, 1, 1); cycle("bld_s1");
    check("bld_s1_ifIdWr", 10'(ifIdWr), 10'd0);
    advance(); cycle("bld_s2");
    check("bld_s2_ifIdWr", 10'(ifIdWr), 10'd0);
    advance(); cycle("bld_go");
    check("bld_go_flush", 10'(flush), 10'd1);
    check("bld_go_nofwd", 10'(idFwdB), 10'd0);
    advance(); idle(3);
    // Register zero never forwards
    setId(1, 2, 0, 1, 1, 1, 0, 0, 0, 0); cycle("add_r0"); advance();
    setId(0, 0, 8, 1, 1, 1, 0, 0, 1, 0); cycle("use_r0");
    check("r0_exFwd", 10'(exFwd), 10'd0);
    check("r0_idFwd", 10'({idFwdA, idFwdB}), 10'd0);
    advance(); idle(3);
    // Reset in the middle of a load-use stall
    setId(2, 0, 5, 1, 0, 1, 1, 0, 0, 0); cycle("lw_r5c"); advance();
    setId(1, 5, 7, 1, 1, 1, 0, 0, 0, 0); cycle("mid_stall");
    check("mid_stall_bubble", 10'(bubble), 10'd1);
    advance();
    reset = 0; cycle("mid_rst");
    check("mid_rst_ifIdWr", 10'(ifIdWr), 10'd1);
    advance();
    reset = 1; cycle("after_rst");
    check("after_rst_bubble", 10'(bubble), 10'd0);
    check("after_rst_ifIdWr", 10'(ifIdWr), 10'd1);
    advance(); idle(2);
`ifdef HAZARD_STALL_COUNT_EN
    reset = 0; idle(1); reset = 1;
    for (int i = 0; i < 3; i++) begin loadUse(); idle(2); end
    check("cnt_three", 10'(stallCount), 10'd3);
    for (int i = 0; i < 20; i++) loadUse();
    check("cnt_sat", 10'(stallCount), 10'((1 << SCW) - 1));
    loadUse();
    check("cnt_sat_hold", 10'(stallCount), 10'((1 << SCW) - 1));
    idle(2);
`endif
    // Random instruction stream; stalled instructions are held, flushed slots become nops
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) != 0);
      if (expStall) ;
      else if (expFlush) nop();
      else begin
        int k;
        k = $urandom_range(0, 4);
        setId($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              k <= 1, k == 1, k == 2, k == 3, $urandom_range(0, 1) == 1);
      end
      cycle("rand");
      advance();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
